mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single 16-bit memory port (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata/mem_resp/mem_rdata) between two requesters: instruction-fetch (i_*) and data (d_*).
- Each requester uses the same handshake as the memory: it holds read or write plus its operands until it sees resp.
- The arbiter picks one requester, latches that request, drives memory from the latched copy and routes mem_resp and mem_rdata back to the winner.
- Sits between the datapath/control and the memory model.

Parameters:
ADDR_WIDTH, 16, address width of all ports
DATA_WIDTH, 16, data width; byte-enable width is DATA_WIDTH/8

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_read  in  1  instruction-port read request
i_write  in  1  instruction-port write request
i_byte_enable  in  DATA_WIDTH/8  instruction-port write mask
i_address  in  ADDR_WIDTH  instruction-port address
i_wdata  in  DATA_WIDTH  instruction-port write data
i_resp  out  1  instruction-port completion, one cycle
i_rdata  out  DATA_WIDTH  instruction-port read data, valid with i_resp
d_read, d_write, d_byte_enable, d_address, d_wdata  in  same widths as i_*  data-port request
d_resp  out  1  data-port completion
d_rdata  out  DATA_WIDTH  data-port read data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_byte_enable  out  DATA_WIDTH/8  memory write mask
mem_address  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_resp  in  1  memory completion
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- States: IDLE, BUSY.
- Registers: grant (I or D), last_grant, latched op (rd/wr), addr, wdata, mask.
- Reset: state=IDLE, last_grant=D (so I wins the first tie), latches cleared. While IDLE: mem_read=mem_write=0, i_resp=d_resp=0; mem_address, mem_wdata and mem_byte_enable show the latches (0 after reset).
- A requester is pending when read|write is 1. If both read and write are 1, write wins and read is ignored.
- IDLE -> BUSY on a clock edge where any requester is pending:
  - One pending: grant it.
  - Both pending: grant the requester that is not last_grant (round-robin).
  - On the same edge, latch the winner's op, address, wdata and mask.
- BUSY:
  - mem_read/mem_write driven from the latched op; mem_address, mem_wdata and mem_byte_enable from the latches.
  - Requester-side changes during BUSY are ignored.
- Completion: when mem_resp=1 in BUSY, the granted port's resp=mem_resp combinationally and its rdata=mem_rdata in the same cycle. The other port's resp=0.
- At that edge: state -> IDLE, last_grant <= grant. mem strobes are 0 in the next cycle.
- rdata of a non-granted port is don't-care; drive 0.
- Latency: request first visible at cycle N -> memory strobe at N+1 -> resp in the cycle mem_resp arrives. At least one IDLE cycle separates back-to-back transactions.
- Request withdrawn mid-transaction: the transaction still completes and resp still pulses.
- mem_resp while IDLE: ignored; no resp to either port.
- rst mid-transaction: at the next edge return to reset values. The pending memory access is abandoned and no resp is issued.
- Starvation bound: with both ports continuously pending, grants strictly alternate.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum {IDLE, BUSY} arb_state_t
  - typedef enum {GNT_I, GNT_D} grant_t
  - struct mem_req_t {read, write, byte_enable, address, wdata}
- One sub-module, arb_req_latch: captures a mem_req_t on a load strobe with synchronous clear.
- Arbitration FSM and response routing stay in mem_arbiter.

Test Plan:
- rst=1 for 2 cycles then 0, no requests -> all mem strobes 0, i_resp=d_resp=0, mem_address=0x0000.
- i_read=1, i_address=0x1000; memory responds after 3 cycles with rdata 0xABCD -> mem_read rises the cycle after the request, mem_address=0x1000, i_resp=1 with i_rdata=0xABCD, d_resp stays 0.
- Both ports pending from reset: i_read @0x2000, d_write @0x3000 wdata 0x55AA mask 2'b01 -> I served first, then D. Memory sees the write with 0x55AA/2'b01. Responses arrive in the order i_resp then d_resp.
- Both ports continuously pending for 6 transactions -> grant order I,D,I,D,I,D.
- d_write issued, then d_write and d_address changed during BUSY -> memory still sees the original address and wdata; d_resp pulses once.
- rst asserted while BUSY -> mem_read/mem_write 0 the next cycle, no resp; a later mem_resp in IDLE is ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, grant id, request word.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a; requesters hold their request until they see resp.
package mem_arb_pkg;

  // Field widths of the latched request word; the arbiter's ADDR_WIDTH and
  // DATA_WIDTH parameters default to these and are expected to match them.
  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 16;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ARB_BE_W-1:0]   byte_enable;
    logic [ARB_ADDR_W-1:0] address;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

  // The requester that did not win last time; used to break ties.
  function automatic grant_t other_port(input grant_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

  // Pack a requester's port signals into a request word. A requester that
  // raises both strobes is treated as a write: the read is dropped here so
  // memory never sees both strobes at once.
  function automatic mem_req_t make_req(
    input logic                  rd,
    input logic                  wr,
    input logic [ARB_BE_W-1:0]   be,
    input logic [ARB_ADDR_W-1:0] addr,
    input logic [ARB_DATA_W-1:0] wd
  );
    mem_req_t r;
    r.read        = rd & ~wr;
    r.write       = wr;
    r.byte_enable = be;
    r.address     = addr;
    r.wdata       = wd;
    return r;
  endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Holding register for the granted request; memory is driven from this copy.
// Latency: captures on the load edge, visible the following cycle.
// Backpressure: none; load is only pulsed by the arbiter when it is idle.
module arb_req_latch
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  logic     load,
  input  mem_req_t req_in,
  output mem_req_t req_q
);

  // Synchronous clear wins over load so a reset mid-grant leaves the latch empty.
  always_ff @(posedge clk) begin
    if (clr) begin
      req_q <= '0;
    end else if (load) begin
      req_q <= req_in;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction (i_*) and data (d_*) requesters.
// Latency: request seen at cycle N -> memory strobe at N+1 -> resp with mem_resp.
// Backpressure: requesters hold until resp; one idle cycle between transactions.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic                    i_resp,
  output logic [DATA_WIDTH-1:0]   i_rdata,

  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_resp,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_resp,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_t state_q, state_nxt;
  grant_t     grant_q, grant_nxt;
  grant_t     last_q,  last_nxt;

  mem_req_t   i_req, d_req;
  mem_req_t   win_req;
  mem_req_t   lat_q;
  logic       i_pend, d_pend;
  logic       load;

  // Normalise both requesters into request words and flag who is asking.
  always_comb begin
    i_req  = make_req(i_read, i_write, i_byte_enable, i_address, i_wdata);
    d_req  = make_req(d_read, d_write, d_byte_enable, d_address, d_wdata);
    i_pend = i_read | i_write;
    d_pend = d_read | d_write;
  end

  // Arbitration next-state, grant selection, latch load and all port outputs.
  always_comb begin
    state_nxt       = state_q;
    grant_nxt       = grant_q;
    last_nxt        = last_q;
    load            = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = lat_q.address;
    mem_wdata       = lat_q.wdata;
    mem_byte_enable = lat_q.byte_enable;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    i_rdata         = '0;
    d_rdata         = '0;

    case (state_q)
      IDLE: begin
        // A stray mem_resp here belongs to no one and is dropped.
        if (i_pend || d_pend) begin
          if (i_pend && d_pend) begin
            grant_nxt = other_port(last_q);
          end else if (i_pend) begin
            grant_nxt = GNT_I;
          end else begin
            grant_nxt = GNT_D;
          end
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        // Requester inputs are not looked at here; memory runs off the latch.
        mem_read  = lat_q.read;
        mem_write = lat_q.write;
        if (mem_resp) begin
          if (grant_q == GNT_I) begin
            i_resp  = 1'b1;
            i_rdata = mem_rdata;
          end else begin
            d_resp  = 1'b1;
            d_rdata = mem_rdata;
          end
          state_nxt = IDLE;
          last_nxt  = grant_q;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    win_req = (grant_nxt == GNT_D) ? d_req : i_req;
  end

  // FSM state, current grant and round-robin history; reset favours I first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GNT_I;
      last_q  <= GNT_D;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
    end
  end

  arb_req_latch u_req_latch (
    .clk    (clk),
    .clr    (rst),
    .load   (load),
    .req_in (win_req),
    .req_q  (lat_q)
  );

endmodule
